rom_readback: RTL and testbench

- Read-side counterpart of the program loader. On request it walks a range of program-ROM addresses and streams each 16-bit instruction word out to the host over a valid/ready handshake.
- Keeps a running 16-bit additive checksum of the streamed words.
- Shares the ROM port with the loader through an external mux, and is used for program verify and dump.
- The block only reads memory; it never writes it.

---
 rtl/rom_readback.sv | 117 +++++++++++
 tb/tb_rom_readback.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_readback.sv
// Streams a range of program-ROM words to the host over valid/ready and
// keeps a running 16-bit additive checksum of the words the host accepted.
module rom_readback #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] startAddr,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] dataOut,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND, DONE} state_t;

  // The WAIT counter loads latency-1 and the word is captured when it hits zero.
  localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

  state_t            state;
  logic [ADDR_W-1:0] address;
  logic [ADDR_W-1:0] remaining;
  logic [1:0]        wait_cnt;

  assign mem_address = address;

  // Outputs are registered alongside the state so each one is asserted
  // exactly while the FSM sits in its owning state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      address   <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
      dataOut   <= '0;
      checksum  <= '0;
      mem_re    <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_re <= 1'b0;
      valid  <= 1'b0;
      done   <= 1'b0;
      if (state != IDLE && abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              address   <= startAddr;
              remaining <= length;
              checksum  <= '0;
              busy      <= 1'b1;
              if (length == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state  <= FETCH;
                mem_re <= 1'b1;
              end
            end
          end
          FETCH: begin
            state    <= WAIT;
            wait_cnt <= WAIT_LAST;
          end
          WAIT: begin
            if (wait_cnt == '0) begin
              dataOut <= mem_rd_data;
              valid   <= 1'b1;
              state   <= SEND;
            end else begin
              wait_cnt <= wait_cnt - 2'd1;
            end
          end
          SEND: begin
            if (ready) begin
              checksum  <= checksum + dataOut;
              address   <= address + ADDR_W'(1);
              remaining <= remaining - ADDR_W'(1);
              if (remaining == ADDR_W'(1)) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state  <= FETCH;
                mem_re <= 1'b1;
              end
            end else begin
              valid <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_readback.sv
// Self-checking bench for rom_readback: a ROM array is the reference model and
// every expected word/checksum is derived from it with plain arithmetic.
module tb_rom_readback;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [14:0] startAddr;
  logic [14:0] length;
  logic [14:0] mem_address;
  logic        mem_re;
  logic [15:0] mem_rd_data;
  logic [15:0] dataOut;
  logic        valid;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] checksum;

  logic [15:0] rom [0:32767];
  logic [15:0] rd_q;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] got_words[$];
  logic [14:0] got_addrs[$];
  logic [15:0] stall_data[$];
  int          rise_cyc[$];
  int          done_cnt;
  int          done_cyc;
  int          stall_re;
  int          stall_novalid;
  bit          timed_out;

  rom_readback #(.ADDR_W(15), .DATA_W(16), .READ_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .startAddr(startAddr), .length(length), .mem_address(mem_address),
    .mem_re(mem_re), .mem_rd_data(mem_rd_data), .dataOut(dataOut),
    .valid(valid), .ready(ready), .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // One-cycle-latency ROM behind the read strobe.
  always @(posedge clk) begin
    if (mem_re) rd_q <= rom[mem_address];
  end
  assign mem_rd_data = rd_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start and then watches the dump cycle by cycle; cycle 1 is the first
  // cycle after the edge that sampled start.
  task automatic run_dump(input logic [14:0] sa, input logic [14:0] len,
                          input int stall_word, input int stall_len,
                          input int abort_word, input int restart_cyc,
                          input bit rand_ready);
    int  cyc;
    int  stall_left;
    bit  stalling;
    bit  prev_valid;
    got_words.delete(); got_addrs.delete(); stall_data.delete(); rise_cyc.delete();
    done_cnt = 0; done_cyc = -1; stall_re = 0; stall_novalid = 0; timed_out = 0;
    stall_left = stall_len; stalling = 0; prev_valid = 0;
    start = 1'b1; startAddr = sa; length = len; ready = 1'b1; abort = 1'b0;
    tick();
    start = 1'b0;
    cyc = 1;
    while (1) begin
      if (cyc > 400) begin
        timed_out = 1;
        break;
      end
      if (mem_re) got_addrs.push_back(mem_address);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (valid && !prev_valid) rise_cyc.push_back(cyc);
      if (!busy) break;
      if (cyc == restart_cyc) begin
        start = 1'b1; startAddr = 15'h5555; length = 15'd1;
      end else begin
        start = 1'b0;
      end
      if (!stalling && stall_left > 0 && valid && got_words.size() == stall_word)
        stalling = 1;
      abort = 1'b0;
      if (stalling) begin
        ready = 1'b0;
        stall_data.push_back(dataOut);
        if (mem_re) stall_re++;
        if (!valid) stall_novalid++;
        stall_left--;
        if (stall_left == 0) stalling = 0;
      end else begin
        ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (valid && got_words.size() == abort_word) begin
          abort = 1'b1;
          ready = 1'b1;
        end
      end
      if (valid && ready && !abort) got_words.push_back(dataOut);
      prev_valid = valid;
      tick();
      cyc++;
    end
    start = 1'b0; abort = 1'b0; ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    tests_run++;
    if ({mem_re, valid, busy, done} !== 4'b0 || dataOut !== 16'h0 ||
        checksum !== 16'h0 || mem_address !== 15'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got re=%b v=%b b=%b d=%b data=%h sum=%h addr=%h expected all 0",
               mem_re, valid, busy, done, dataOut, checksum, mem_address);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    run_dump(15'h0010, 15'd4, -1, 0, -1, -1, 0);
    tests_run++;
    if (timed_out !== 1'b0 || got_words.size() != 4) begin
      tests_failed++;
      $display("[TB] FAIL basic_count: got %0d words timeout=%0d expected 4", got_words.size(), timed_out);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (got_words[i] !== rom[15'h0010 + i]) begin
          tests_failed++;
          $display("[TB] FAIL basic_word%0d: got %h expected %h", i, got_words[i], rom[15'h0010 + i]);
        end
      end
    end
    tests_run++;
    if (rise_cyc.size() != 4) begin
      tests_failed++;
      $display("[TB] FAIL basic_rises: got %0d valid rises expected 4", rise_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (rise_cyc[i] != 3 + i * (2 + LAT)) begin
          tests_failed++;
          $display("[TB] FAIL basic_rise%0d: got cycle %0d expected %0d", i, rise_cyc[i], 3 + i * (2 + LAT));
        end
      end
    end
    tests_run++;
    if (checksum !== 16'hAAAA) begin
      tests_failed++;
      $display("[TB] FAIL basic_checksum: got %h expected aaaa", checksum);
    end
    tests_run++;
    if (done_cnt != 1 || done_cyc != 1 + 4 * (2 + LAT)) begin
      tests_failed++;
      $display("[TB] FAIL basic_done: got %0d pulses at %0d expected 1 at %0d", done_cnt, done_cyc, 1 + 4 * (2 + LAT));
    end
  endtask

  task automatic test_backpressure();
    run_dump(15'h0010, 15'd4, 1, 5, -1, -1, 0);
    tests_run++;
    if (stall_data.size() != 5 || stall_re != 0 || stall_novalid != 0) begin
      tests_failed++;
      $display("[TB] FAIL bp_stall: got %0d stall cycles re=%0d novalid=%0d expected 5,0,0",
               stall_data.size(), stall_re, stall_novalid);
    end
    foreach (stall_data[i]) begin
      tests_run++;
      if (stall_data[i] !== 16'h2222) begin
        tests_failed++;
        $display("[TB] FAIL bp_data%0d: got %h expected 2222", i, stall_data[i]);
      end
    end
    tests_run++;
    if (checksum !== 16'hAAAA || got_words.size() != 4 || done_cnt != 1) begin
      tests_failed++;
      $display("[TB] FAIL bp_final: got sum=%h words=%0d done=%0d expected aaaa,4,1",
               checksum, got_words.size(), done_cnt);
    end
  endtask

  task automatic test_empty_and_overflow();
    run_dump(15'h0200, 15'd0, -1, 0, -1, -1, 0);
    tests_run++;
    if (done_cnt != 1 || done_cyc != 1 || rise_cyc.size() != 0 || got_addrs.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL empty: got done=%0d at %0d rises=%0d reads=%0d expected 1 at 1,0,0",
               done_cnt, done_cyc, rise_cyc.size(), got_addrs.size());
    end
    run_dump(15'h0100, 15'd2, -1, 0, -1, -1, 0);
    tests_run++;
    if (checksum !== 16'h0001 || done_cnt != 1) begin
      tests_failed++;
      $display("[TB] FAIL overflow_checksum: got %h done=%0d expected 0001,1", checksum, done_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [14:0] exp_addr [3];
    exp_addr = '{15'h7FFE, 15'h7FFF, 15'h0000};
    run_dump(15'h7FFE, 15'd3, -1, 0, -1, -1, 0);
    tests_run++;
    if (got_addrs.size() != 3) begin
      tests_failed++;
      $display("[TB] FAIL wrap_reads: got %0d reads expected 3", got_addrs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (got_addrs[i] !== exp_addr[i] || got_words[i] !== rom[exp_addr[i]]) begin
          tests_failed++;
          $display("[TB] FAIL wrap_addr%0d: got addr %h word %h expected %h word %h",
                   i, got_addrs[i], got_words[i], exp_addr[i], rom[exp_addr[i]]);
        end
      end
    end
  endtask

  task automatic test_abort();
    run_dump(15'h0010, 15'd4, -1, 0, 1, -1, 0);
    tests_run++;
    if (done_cnt != 0 || busy !== 1'b0 || valid !== 1'b0 || timed_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_state: got done=%0d busy=%b valid=%b timeout=%0d expected 0,0,0,0",
               done_cnt, busy, valid, timed_out);
    end
    tests_run++;
    if (checksum !== 16'h1111) begin
      tests_failed++;
      $display("[TB] FAIL abort_checksum: got %h expected 1111", checksum);
    end
  endtask

  task automatic test_busy_start();
    for (int r = 3; r <= 4; r++) begin
      run_dump(15'h0010, 15'd4, -1, 0, -1, r, 0);
      tests_run++;
      if (checksum !== 16'hAAAA || got_words.size() != 4 || done_cnt != 1 ||
          done_cyc != 1 + 4 * (2 + LAT)) begin
        tests_failed++;
        $display("[TB] FAIL busy_start%0d: got sum=%h words=%0d done=%0d at %0d expected aaaa,4,1 at %0d",
                 r, checksum, got_words.size(), done_cnt, done_cyc, 1 + 4 * (2 + LAT));
      end
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; startAddr = 15'h0020; length = 15'd3;
    tick();
    start = 1'b0;
    tick();
    #3;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({mem_re, valid, busy, done} !== 4'b0 || dataOut !== 16'h0 ||
        checksum !== 16'h0 || mem_address !== 15'h0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got re=%b v=%b b=%b d=%b data=%h sum=%h addr=%h expected all 0",
               mem_re, valid, busy, done, dataOut, checksum, mem_address);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    run_dump(15'h0010, 15'd4, -1, 0, -1, -1, 0);
    tests_run++;
    if (checksum !== 16'hAAAA || done_cnt != 1 || got_words.size() != 4) begin
      tests_failed++;
      $display("[TB] FAIL after_reset: got sum=%h done=%0d words=%0d expected aaaa,1,4",
               checksum, done_cnt, got_words.size());
    end
  endtask

  task automatic test_random();
    logic [14:0] sa;
    logic [14:0] len;
    logic [15:0] sum;
    int          bad;
    for (int n = 0; n < 20; n++) begin
      sa  = 15'($urandom);
      len = 15'($urandom_range(1, 7));
      run_dump(sa, len, -1, 0, -1, -1, 1);
      sum = 16'h0;
      bad = 0;
      for (int i = 0; i < int'(len); i++) begin
        sum = sum + rom[15'(sa + 15'(i))];
        if (i >= got_words.size() || got_words[i] !== rom[15'(sa + 15'(i))]) bad++;
      end
      tests_run++;
      if (bad != 0 || got_words.size() != int'(len) || checksum !== sum || done_cnt != 1) begin
        tests_failed++;
        $display("[TB] FAIL random%0d: got words=%0d bad=%0d sum=%h done=%0d expected %0d,0,%h,1",
                 n, got_words.size(), bad, checksum, done_cnt, len, sum);
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1;
    startAddr = '0; length = '0;
    for (int i = 0; i < 32768; i++) rom[i] = 16'($urandom);
    rom[15'h0010] = 16'h1111;
    rom[15'h0011] = 16'h2222;
    rom[15'h0012] = 16'h3333;
    rom[15'h0013] = 16'h4444;
    rom[15'h0100] = 16'hFFFF;
    rom[15'h0101] = 16'h0002;
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_and_overflow();
    test_wrap();
    test_abort();
    test_busy_start();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
